// File: rtl/me_result_stage.sv
// me_result_stage: memory-stage result select with multi-cycle loads, byte extraction and forwarding.
// Optional load timeout is enabled by defining ME_LOAD_TIMEOUT_EN.
module me_result_stage #(
    parameter int DATA_W       = 16,
    parameter int REG_AW       = 3,
    parameter int BSEL_W       = 1,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_wen,
    input  logic [1:0]        ex_mem_ctl,
    input  logic              ex_byte,
    input  logic [BSEL_W-1:0] ex_bsel,
    input  logic              ex_signed,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              me_stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_result,
    output logic [REG_AW-1:0] wb_dest,
    output logic              wb_wen,
    output logic              fwd_pending,
    output logic [REG_AW-1:0] fwd_dest,
    output logic              me_err
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t            state, state_next;
    logic [REG_AW-1:0] ld_dest;
    logic              ld_wen, ld_byte, ld_signed;
    logic [BSEL_W-1:0] ld_bsel;
    logic [7:0]        lane;
    logic [DATA_W-1:0] ld_data;
    logic              accept_load, load_done, timeout;

    if (DATA_W < 16 || DATA_W % 8 != 0 || (1 << BSEL_W) != DATA_W / 8) begin : g_bad_width
        $error("me_result_stage: DATA_W/BSEL_W inconsistent");
    end
    if (LOAD_TIMEOUT < 1 || LOAD_TIMEOUT > 255) begin : g_bad_timeout
        $error("me_result_stage: LOAD_TIMEOUT out of range");
    end

    assign accept_load = state == IDLE && ex_valid && ex_mem_ctl == 2'b10;
    assign load_done   = state == WAIT_LOAD && (mem_rvalid || timeout);
    assign lane        = mem_rdata[{ld_bsel, 3'b000} +: 8];
    assign ld_data     = ld_byte ? {{(DATA_W-8){ld_signed & lane[7]}}, lane} : mem_rdata;
    assign me_stall    = state == WAIT_LOAD && !mem_rvalid;
    assign fwd_pending = state == WAIT_LOAD;
    assign fwd_dest    = fwd_pending ? ld_dest : wb_dest;

`ifdef ME_LOAD_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(LOAD_TIMEOUT - 1);
    logic [7:0] cnt;
    // The limit is hit on the wait edge that would bring cnt up to LOAD_TIMEOUT.
    assign timeout = me_stall && cnt == TO_LIM;
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            me_err <= 1'b0;
        end else begin
            cnt    <= accept_load ? 8'd0 : me_stall ? cnt + 8'd1 : cnt;
            me_err <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign me_err  = 1'b0;
`endif

    always_ff @(negedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        state_next = state == IDLE ? (accept_load ? WAIT_LOAD : IDLE) : (load_done ? IDLE : WAIT_LOAD);
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_result <= '0;
            wb_dest   <= '0;
            wb_wen    <= 1'b0;
            ld_dest   <= '0;
            ld_wen    <= 1'b0;
            ld_byte   <= 1'b0;
            ld_bsel   <= '0;
            ld_signed <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept_load) begin
                ld_dest   <= ex_dest;
                ld_wen    <= ex_wen;
                ld_byte   <= ex_byte;
                ld_bsel   <= ex_bsel;
                ld_signed <= ex_signed;
            end else if (state == IDLE && ex_valid) begin
                wb_valid  <= 1'b1;
                wb_result <= ex_result;
                wb_dest   <= ex_dest;
                wb_wen    <= ex_wen;
            end else if (load_done) begin
                // Arriving data takes priority over a timeout on the same edge.
                wb_valid  <= 1'b1;
                wb_result <= mem_rvalid ? ld_data : '0;
                wb_dest   <= ld_dest;
                wb_wen    <= ld_wen & mem_rvalid;
            end
        end
    end
endmodule

// File: tb/tb_me_result_stage.sv
// tb_me_result_stage: directed table-driven bench for me_result_stage plus reset and timeout sequences.
module tb_me_result_stage;
    localparam int DW = 16, AW = 3, BW = 1;

    logic          clk = 1'b0, rst;
    logic          ex_valid, ex_wen, ex_byte, ex_signed, mem_rvalid;
    logic [DW-1:0] ex_result, mem_rdata;
    logic [AW-1:0] ex_dest;
    logic [1:0]    ex_mem_ctl;
    logic [BW-1:0] ex_bsel;
    logic          me_stall, wb_valid, wb_wen, fwd_pending, me_err;
    logic [DW-1:0] wb_result;
    logic [AW-1:0] wb_dest, fwd_dest;
    int            n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    me_result_stage #(.DATA_W(DW), .REG_AW(AW), .BSEL_W(BW), .LOAD_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result), .ex_dest(ex_dest),
        .ex_wen(ex_wen), .ex_mem_ctl(ex_mem_ctl), .ex_byte(ex_byte), .ex_bsel(ex_bsel),
        .ex_signed(ex_signed), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .me_stall(me_stall),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_dest(wb_dest), .wb_wen(wb_wen),
        .fwd_pending(fwd_pending), .fwd_dest(fwd_dest), .me_err(me_err)
    );

    typedef struct {
        logic          v, w, byt, sg, rv;
        logic [DW-1:0] res, rd;
        logic [AW-1:0] d;
        logic [1:0]    ctl;
        logic [BW-1:0] bsel;
        logic          e_stall, e_wv, e_ww, e_pd;
        logic [DW-1:0] e_wr;
        logic [AW-1:0] e_wd, e_fd;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input int v, res, d, w, ctl, byt, bsel, sg, rd, rv,
                       input int st, wv, wr, wd, ww, pd, fd);
        vec_t x;
        x.v = 1'(v); x.res = DW'(res); x.d = AW'(d); x.w = 1'(w); x.ctl = 2'(ctl);
        x.byt = 1'(byt); x.bsel = BW'(bsel); x.sg = 1'(sg); x.rd = DW'(rd); x.rv = 1'(rv);
        x.e_stall = 1'(st); x.e_wv = 1'(wv); x.e_wr = DW'(wr); x.e_wd = AW'(wd);
        x.e_ww = 1'(ww); x.e_pd = 1'(pd); x.e_fd = AW'(fd);
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input vec_t x);
        ex_valid = x.v; ex_result = x.res; ex_dest = x.d; ex_wen = x.w; ex_mem_ctl = x.ctl;
        ex_byte = x.byt; ex_bsel = x.bsel; ex_signed = x.sg; mem_rdata = x.rd; mem_rvalid = x.rv;
    endtask

    task automatic load(input int d, input int w);
        ex_valid = 1'b1; ex_mem_ctl = 2'b10; ex_dest = AW'(d); ex_wen = 1'(w); ex_byte = 1'b0;
        mem_rvalid = 1'b0;
        tick();
        ex_valid = 1'b0;
    endtask

    initial begin
        ex_valid = 0; ex_result = '0; ex_dest = '0; ex_wen = 0; ex_mem_ctl = '0; ex_byte = 0;
        ex_bsel = '0; ex_signed = 0; mem_rdata = '0; mem_rvalid = 0;
        rst = 1'b1;
        #3;
        chk("rst wb_valid", 32'(wb_valid), 0);
        chk("rst wb_result", 32'(wb_result), 0);
        chk("rst fwd_pending", 32'(fwd_pending), 0);
        chk("rst me_err", 32'(me_err), 0);
        rst = 1'b0;
        tick();

        add(1, 'h1234, 3, 1, 0, 0, 0, 0, 0,      0,  0, 1, 'h1234, 3, 1, 0, 3);
        add(1, 'hBEEF, 5, 1, 0, 0, 0, 0, 0,      0,  0, 1, 'hBEEF, 5, 1, 0, 5);
        add(0, 0,      0, 0, 0, 0, 0, 0, 0,      0,  0, 0, 'hBEEF, 5, 1, 0, 5);
        add(1, 'h9999, 6, 1, 2, 0, 0, 0, 'hDEAD, 1,  0, 0, 'hBEEF, 5, 1, 1, 6);
        add(1, 'h7777, 2, 1, 0, 0, 0, 0, 'hDEAD, 0,  1, 0, 'hBEEF, 5, 1, 1, 6);
        add(1, 'h7777, 2, 1, 0, 0, 0, 0, 'hDEAD, 0,  1, 0, 'hBEEF, 5, 1, 1, 6);
        add(1, 'h7777, 2, 1, 0, 0, 0, 0, 'hDEAD, 0,  1, 0, 'hBEEF, 5, 1, 1, 6);
        add(1, 'h7777, 2, 1, 0, 0, 0, 0, 'hA55A, 1,  0, 1, 'hA55A, 6, 1, 0, 6);
        add(1, 'h7777, 2, 1, 0, 0, 0, 0, 'hA55A, 0,  0, 1, 'h7777, 2, 1, 0, 2);
        add(1, 0,      1, 1, 2, 1, 1, 1, 0,      0,  0, 0, 'h7777, 2, 1, 1, 1);
        add(0, 0,      0, 0, 0, 0, 0, 0, 'h80F0, 1,  0, 1, 'hFF80, 1, 1, 0, 1);
        add(1, 0,      4, 1, 2, 1, 1, 0, 0,      0,  0, 0, 'hFF80, 1, 1, 1, 4);
        add(0, 0,      0, 0, 0, 0, 0, 0, 'h80F0, 1,  0, 1, 'h0080, 4, 1, 0, 4);
        add(1, 0,      7, 1, 2, 1, 0, 1, 0,      0,  0, 0, 'h0080, 4, 1, 1, 7);
        add(0, 0,      0, 0, 0, 0, 0, 0, 'h80F0, 1,  0, 1, 'hFFF0, 7, 1, 0, 7);
        add(1, 'h0042, 3, 0, 3, 0, 0, 0, 0,      0,  0, 1, 'h0042, 3, 0, 0, 3);
        add(1, 'h5555, 0, 0, 1, 0, 0, 0, 0,      0,  0, 1, 'h5555, 0, 0, 0, 0);
        add(0, 0,      0, 0, 0, 0, 0, 0, 0,      0,  0, 0, 'h5555, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d me_stall", i), 32'(me_stall), 32'(vecs[i].e_stall));
            tick();
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wv));
            chk($sformatf("v%0d wb_result", i), 32'(wb_result), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d wb_dest", i), 32'(wb_dest), 32'(vecs[i].e_wd));
            chk($sformatf("v%0d wb_wen", i), 32'(wb_wen), 32'(vecs[i].e_ww));
            chk($sformatf("v%0d fwd_pending", i), 32'(fwd_pending), 32'(vecs[i].e_pd));
            chk($sformatf("v%0d fwd_dest", i), 32'(fwd_dest), 32'(vecs[i].e_fd));
            chk($sformatf("v%0d me_err", i), 32'(me_err), 0);
        end

        // Reset arrives while a load is waiting for data.
        load(5, 1);
        tick();
        chk("midrst pending before", 32'(fwd_pending), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst fwd_pending", 32'(fwd_pending), 0);
        chk("midrst fwd_dest", 32'(fwd_dest), 0);
        chk("midrst me_stall", 32'(me_stall), 0);
        chk("midrst wb_valid", 32'(wb_valid), 0);
        chk("midrst wb_result", 32'(wb_result), 0);
        chk("midrst wb_dest", 32'(wb_dest), 0);
        chk("midrst wb_wen", 32'(wb_wen), 0);
        chk("midrst me_err", 32'(me_err), 0);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 16'h1111;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("postrst%0d wb_valid", k), 32'(wb_valid), 0);
            chk($sformatf("postrst%0d fwd_pending", k), 32'(fwd_pending), 0);
        end

`ifdef ME_LOAD_TIMEOUT_EN
        load(2, 1);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("to edge%0d me_stall", k), 32'(me_stall), 1);
            tick();
            chk($sformatf("to edge%0d wb_valid", k), 32'(wb_valid), 0);
            chk($sformatf("to edge%0d me_err", k), 32'(me_err), 0);
        end
        tick();
        chk("to wb_valid", 32'(wb_valid), 1);
        chk("to wb_wen", 32'(wb_wen), 0);
        chk("to wb_result", 32'(wb_result), 0);
        chk("to me_err", 32'(me_err), 1);
        chk("to fwd_pending", 32'(fwd_pending), 0);
        tick();
        chk("to after me_err", 32'(me_err), 0);
        chk("to after wb_valid", 32'(wb_valid), 0);
        load(2, 1);
        for (int k = 1; k <= 3; k++) tick();
        mem_rvalid = 1'b1; mem_rdata = 16'h1357;
        tick();
        chk("race wb_valid", 32'(wb_valid), 1);
        chk("race wb_result", 32'(wb_result), 'h1357);
        chk("race wb_wen", 32'(wb_wen), 1);
        chk("race me_err", 32'(me_err), 0);
`else
        load(6, 1);
        for (int k = 0; k < 20; k++) tick();
        chk("nowait me_stall", 32'(me_stall), 1);
        chk("nowait fwd_pending", 32'(fwd_pending), 1);
        chk("nowait wb_valid", 32'(wb_valid), 0);
        chk("nowait me_err", 32'(me_err), 0);
        mem_rvalid = 1'b1; mem_rdata = 16'h2468;
        tick();
        chk("late wb_valid", 32'(wb_valid), 1);
        chk("late wb_result", 32'(wb_result), 'h2468);
        chk("late wb_dest", 32'(wb_dest), 6);
`endif
        mem_rvalid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
